a429_rx_arbiter: RTL and testbench
==================================

// Module: a429_rx_arbiter
// PURPOSE
//  Round-robin scheduler that drains 32-bit ARINC 429 words from NUM_CH receiver FIFOs
//  (one per RECModule instance) into a single host-side valid/ready stream.
//  Applies a per-label acceptance filter and an odd-parity check on each word.
//  Counts the words it drops. Sits between the receiver FIFOs and the host/bus interface.
// PARAMETERS
//  NUM_CH        4   number of receiver channels (2..8)
//  CHW           2   channel index width, $clog2(NUM_CH)
//  DROP_BAD_PAR  0   1: discard words failing odd parity; 0: forward them with out_parity_err=1
// PORTS
//  Clk             in   1         system clock (24 MHz)
//  Clr             in   1         asynchronous reset, active-high
//  rx_empty        in   NUM_CH    per-channel FIFO empty flag
//  rx_rd           out  NUM_CH    one-hot FIFO read strobe, 1-cycle pulse
//  rx_data         in   NUM_CH*32 FIFO read data; channel c is bits [32c+31:32c]; valid the cycle after rx_rd
//  cfg_we          in   1         label filter write strobe
//  cfg_label       in   8         label address to write
//  cfg_en          in   1         new enable bit for cfg_label
//  out_valid       out  1         output word valid
//  out_ready       in   1         host accepts word
//  out_word        out  32        forwarded ARINC word
//  out_ch          out  CHW       source channel of out_word
//  out_parity_err  out  1         out_word failed odd parity
//  drop_cnt        out  16        saturating count of dropped words
// BEHAVIOUR
//  Reset (async, Clr=1):
//   - rx_rd=0, out_valid=0, out_word=0, out_ch=0, out_parity_err=0, drop_cnt=0
//   - rr_ptr=NUM_CH-1, so channel 0 wins first
//   - all 256 label enables=1 (pass all); FSM=IDLE
//  Word fields: label=word[7:0]; parity=word[31]; valid word has odd popcount over [31:0].
//  FSM:
//   IDLE  - if any rx_empty[c]==0: grant = first non-empty channel after rr_ptr (wrapping);
//           pulse rx_rd[grant]; go WAIT. Otherwise stay in IDLE.
//   WAIT  - latch rx_data[grant] into word_q; go CHECK.
//   CHECK - keep = label_en[word_q[7:0]] && !(DROP_BAD_PAR && par_bad).
//           keep=1: load out_word/out_ch/out_parity_err, set out_valid; go OUT.
//           keep=0: drop_cnt+=1, saturating at 16'hFFFF; rr_ptr=grant; go IDLE.
//   OUT   - hold out_valid and all out_* stable until out_valid && out_ready.
//           On the handshake: clear out_valid, rr_ptr=grant, go IDLE.
//  Latency: out_valid rises 3 cycles after the cycle rx_rd is high.
//   Best-case throughput is one word per 4 cycles, far above the 100 kbit/s line rate.
//  rx_rd fires only in IDLE, so at most one word is in flight; never reads an empty FIFO.
//  Backpressure: while in OUT, no further rx_rd is issued.
//  cfg_we is accepted in any state. A write in the same cycle as CHECK does not affect
//   that word; CHECK uses the pre-write enable value.
//  rr_ptr advances on both forwarded and dropped words, so a channel flooding filtered
//   labels cannot starve the others.
//  Clr mid-operation: any in-flight word is discarded and the label table is restored to all-ones.
// STRUCTURE
//  a429_pkg (shared package):
//   - LABEL_LSB/MSB and PARITY_BIT constants
//   - FSM state localparams (IDLE/WAIT/CHECK/OUT)
//   - function odd_parity_ok(word)
//  rr_pick sub-module: combinational round-robin picker (req, ptr -> grant_idx, any).
//  Everything else is local: 256x1 label enable register array, FSM, counters.
// TESTING
//  1 ch0 holds 0x8000005A (odd parity), out_ready=1
//    -> rx_rd=0001; out_valid 3 cycles later; out_word=0x8000005A, out_ch=0, out_parity_err=0
//  2 all 4 channels hold 2 words each, out_ready=1
//    -> grant order 0,1,2,3,0,1,2,3; 8 handshakes; rx_rd never asserted on an empty channel
//  3 cfg_we with label 0x5A, cfg_en=0; then send 0x8000005A on ch1
//    -> no out_valid; drop_cnt=1; the next grant goes to ch2 if it is non-empty
//  4 word 0x0000005A (even parity) with DROP_BAD_PAR=0 -> forwarded with out_parity_err=1;
//    same word with DROP_BAD_PAR=1 -> dropped, drop_cnt increments
//  5 out_ready=0 for 10 cycles while in OUT
//    -> out_word/out_ch stable, no rx_rd pulses; the word completes when out_ready=1
//  6 assert Clr while out_valid=1
//    -> all outputs 0 immediately; after release, ch0 is granted first and label 0x5A passes again

Source files
------------

// File: rtl/a429_pkg.sv
// Shared definitions for the ARINC 429 receive path: word field positions,
// arbiter FSM state encoding and the odd-parity helper.
package a429_pkg;

  localparam int WORD_W     = 32;
  localparam int LABEL_LSB  = 0;
  localparam int LABEL_MSB  = 7;
  localparam int PARITY_BIT = 31;
  localparam int NUM_LABELS = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_OUT   = 2'd3
  } arb_state_e;

  // An ARINC 429 word is good when its population count, parity bit included, is odd.
  function automatic logic odd_parity_ok(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly after
// ptr, wrapping, so the last-served channel gets the lowest priority.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CHW    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHW-1:0]    ptr,
  output logic [CHW-1:0]    grant_idx,
  output logic              any
);

  logic [CHW-1:0] idx;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CHW'((int'(ptr) + i) % NUM_CH);
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/a429_rx_arbiter.sv
// Round-robin drain of NUM_CH ARINC 429 receiver FIFOs into one valid/ready
// stream, with a per-label acceptance filter, odd-parity check and drop counter.
module a429_rx_arbiter
  import a429_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CHW          = $clog2(NUM_CH),
  parameter bit DROP_BAD_PAR = 1'b0
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic [NUM_CH-1:0]        rx_empty,
  output logic [NUM_CH-1:0]        rx_rd,
  input  logic [NUM_CH*WORD_W-1:0] rx_data,
  input  logic                     cfg_we,
  input  logic [7:0]               cfg_label,
  input  logic                     cfg_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_word,
  output logic [CHW-1:0]           out_ch,
  output logic                     out_parity_err,
  output logic [15:0]              drop_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  arb_state_e             state_q, state_d;
  logic [CHW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]         grant_q, grant_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_W-1:0]      out_word_q, out_word_d;
  logic [CHW-1:0]         out_ch_q, out_ch_d;
  logic                   out_perr_q, out_perr_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic [NUM_LABELS-1:0]  label_en_q, label_en_d;

  logic [CHW-1:0]         pick_idx;
  logic                   pick_any;
  logic                   par_bad;
  logic                   keep;
  logic [WORD_W-1:0]      ch_word [NUM_CH];

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_pick (
    .req       (~rx_empty),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_word[c] = rx_data[c*WORD_W +: WORD_W];
    end
  end

  // The filter lookup uses the registered table, so a write landing in the
  // CHECK cycle only affects later words.
  assign par_bad = !odd_parity_ok(word_q);
  assign keep    = label_en_q[word_q[LABEL_MSB:LABEL_LSB]] && !(DROP_BAD_PAR && par_bad);

  always_comb begin
    label_en_d = label_en_q;
    if (cfg_we) begin
      label_en_d[cfg_label] = cfg_en;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_ch_d    = out_ch_q;
    out_perr_d  = out_perr_q;
    drop_cnt_d  = drop_cnt_q;
    rx_rd       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any && !Clr) begin
          rx_rd[pick_idx] = 1'b1;
          grant_d         = pick_idx;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        word_d  = ch_word[grant_q];
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (keep) begin
          out_word_d  = word_q;
          out_ch_d    = grant_q;
          out_perr_d  = par_bad;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          drop_cnt_d = sat_inc16(drop_cnt_q);
          rr_ptr_d   = grant_q;
          state_d    = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = grant_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= CHW'(NUM_CH - 1);
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_ch_q    <= '0;
      out_perr_q  <= 1'b0;
      drop_cnt_q  <= '0;
      label_en_q  <= '1;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_ch_q    <= out_ch_d;
      out_perr_q  <= out_perr_d;
      drop_cnt_q  <= drop_cnt_d;
      label_en_q  <= label_en_d;
    end
  end

  // Word capture stage: only meaningful once the FSM has passed WAIT.
  always_ff @(posedge Clk) begin
    word_q <= word_d;
  end

  assign out_valid      = out_valid_q;
  assign out_word       = out_word_q;
  assign out_ch         = out_ch_q;
  assign out_parity_err = out_perr_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_a429_rx_arbiter.sv
// Scoreboard bench for a429_rx_arbiter: FIFO models feed the arbiter, stimulus
// queues expected words, and a negedge monitor pops and compares them.
module tb_a429_rx_arbiter;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [3:0]   rx_empty;
  logic [3:0]   rx_rd;
  logic [127:0] rx_data;
  logic         cfg_we, cfg_en;
  logic [7:0]   cfg_label;
  logic         out_valid, out_ready, out_parity_err;
  logic [31:0]  out_word;
  logic [1:0]   out_ch;
  logic [15:0]  drop_cnt;

  logic         clr2 = 1'b0;
  logic         pend2;
  logic [3:0]   rx_empty2, rx_rd2;
  logic [127:0] rx_data2;
  logic         out_valid2, out_perr2;
  logic [31:0]  out_word2;
  logic [1:0]   out_ch2;
  logic [15:0]  drop_cnt2;

  always #5 clk = ~clk;

  a429_rx_arbiter #(.NUM_CH(4), .CHW(2), .DROP_BAD_PAR(1'b0)) dut (
    .Clk(clk), .Clr(clr), .rx_empty(rx_empty), .rx_rd(rx_rd), .rx_data(rx_data),
    .cfg_we(cfg_we), .cfg_label(cfg_label), .cfg_en(cfg_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_ch(out_ch), .out_parity_err(out_parity_err), .drop_cnt(drop_cnt)
  );

  a429_rx_arbiter #(.NUM_CH(4), .CHW(2), .DROP_BAD_PAR(1'b1)) dut2 (
    .Clk(clk), .Clr(clr2), .rx_empty(rx_empty2), .rx_rd(rx_rd2), .rx_data(rx_data2),
    .cfg_we(1'b0), .cfg_label(8'h00), .cfg_en(1'b0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_word(out_word2),
    .out_ch(out_ch2), .out_parity_err(out_perr2), .drop_cnt(drop_cnt2)
  );

  // Receiver FIFO models
  logic [31:0] mem [4][64];
  int          wr_ptr [4] = '{default: 0};
  int          rd_ptr [4] = '{default: 0};
  int          cyc = 0;

  always_comb begin
    for (int c = 0; c < 4; c++) rx_empty[c] = (wr_ptr[c] == rd_ptr[c]);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 4; c++) begin
      if (rx_rd[c]) begin
        rx_data[32*c +: 32] <= mem[c][rd_ptr[c][5:0]];
        rd_ptr[c]           <= rd_ptr[c] + 1;
      end
    end
  end

  // Second instance: one even-parity word on ch0, which must be dropped.
  assign rx_empty2 = {3'b111, ~pend2};
  assign rx_data2  = {96'h0, 32'h0000005A};
  always @(posedge clk) begin
    if (clr2) pend2 <= 1'b1;
    else if (rx_rd2[0]) pend2 <= 1'b0;
  end

  // Scoreboard
  typedef struct packed {logic [1:0] ch; logic [31:0] word; logic perr;} exp_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;
  exp_t sb_q[$];
  chk_t chk_q[$];
  int   grant_log[$];
  int   compared = 0, mismatched = 0;
  int   rd_cyc = 0;
  logic prev_valid = 1'b0;
  logic seen_valid2 = 1'b0;

  always @(negedge clk) begin
    chk_t k;
    exp_t e;
    while (chk_q.size() > 0) begin
      k = chk_q.pop_front();
      compared++;
      if (k.act !== k.exp) begin
        mismatched++;
        $display("FAIL %s: got 0x%0h required 0x%0h", k.name, k.act, k.exp);
      end
    end
    if (clr) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_rd != 4'b0) begin
        compared++;
        if (!$onehot(rx_rd) || (rx_rd & rx_empty) != 4'b0) begin
          mismatched++;
          $display("FAIL rx_rd_legal: rx_rd=%b rx_empty=%b", rx_rd, rx_empty);
        end
        for (int c = 0; c < 4; c++) if (rx_rd[c]) grant_log.push_back(c);
        rd_cyc = cyc;
      end
      if (out_valid && !prev_valid) begin
        compared++;
        if (cyc - rd_cyc != 3) begin
          mismatched++;
          $display("FAIL latency: got %0d cycles required 3", cyc - rd_cyc);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        if (sb_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_word: got ch%0d 0x%08h with nothing expected", out_ch, out_word);
        end else begin
          e = sb_q.pop_front();
          if ({out_ch, out_word, out_parity_err} !== e) begin
            mismatched++;
            $display("FAIL out_word: got ch%0d 0x%08h perr=%b required ch%0d 0x%08h perr=%b",
                     out_ch, out_word, out_parity_err, e.ch, e.word, e.perr);
          end
        end
      end
      prev_valid = out_valid;
    end
    if (!clr2 && out_valid2 && !seen_valid2) begin
      seen_valid2 = 1'b1;
      compared++;
      mismatched++;
      $display("FAIL dut2_forward: got word 0x%08h required drop", out_word2);
    end
  end

  // Stimulus helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [31:0] w);
    mem[c][wr_ptr[c][5:0]] = w;
    wr_ptr[c] = wr_ptr[c] + 1;
  endtask

  task automatic expect_out(input logic [1:0] c, input logic [31:0] w, input logic perr);
    sb_q.push_back({c, w, perr});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask

  function automatic logic [31:0] mkpar(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    r[31] = ~(^w[30:0]);
    return r;
  endfunction

  function automatic logic [31:0] grants_enc();
    logic [31:0] r;
    r = '0;
    foreach (grant_log[i]) r = {r[27:0], 4'(grant_log[i])};
    return r;
  endfunction

  task automatic wait_drain(input string name, input int maxc);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < maxc) begin
      step(1);
      n++;
    end
    check(name, 32'(n < maxc), 32'd1);
    step(4);
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int n;
    n = 0;
    while (!out_valid && n < maxc) begin
      step(1);
      n++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic pulse_reset();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
  endtask

  initial begin
    logic [31:0] w0, w1, w_a, w_b, w_q;
    int rd_during, changed;
    cfg_we = 1'b0; cfg_label = 8'h00; cfg_en = 1'b0; out_ready = 1'b1;
    #2;
    clr = 1'b1; clr2 = 1'b1;
    step(2);
    check("rst_rx_rd", 32'(rx_rd), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    clr = 1'b0; clr2 = 1'b0;
    step(1);

    // 1: single word on ch0
    grant_log.delete();
    push(0, 32'h8000005A);
    expect_out(2'd0, 32'h8000005A, 1'b0);
    wait_drain("t1_drain", 40);
    check("t1_grants", grants_enc(), 32'h0);
    check("t1_grant_cnt", 32'(grant_log.size()), 32'd1);

    // 2: two words per channel, fresh pointer
    pulse_reset();
    grant_log.delete();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        w0 = mkpar(32'h00012300 | 32'(8'h10 * c + k));
        push(c, w0);
        expect_out(2'(c), w0, 1'b0);
      end
    wait_drain("t2_drain", 200);
    check("t2_grants", grants_enc(), 32'h01230123);
    check("t2_grant_cnt", 32'(grant_log.size()), 32'd8);

    // 3: filtered label dropped on ch1, pointer advances past it
    grant_log.delete();
    cfg_we = 1'b1; cfg_label = 8'h5A; cfg_en = 1'b0;
    step(1);
    cfg_we = 1'b0;
    push(1, 32'h8000005A);
    step(12);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t3_no_valid", 32'(out_valid), 32'd0);
    w0 = mkpar(32'h00000033);
    w1 = mkpar(32'h00000044);
    push(0, w0);
    push(2, w1);
    expect_out(2'd2, w1, 1'b0);
    expect_out(2'd0, w0, 1'b0);
    wait_drain("t3_drain", 60);
    check("t3_grants", grants_enc(), 32'h120);

    // 4: even parity forwarded with error flag; dropped by the strict instance
    cfg_we = 1'b1; cfg_label = 8'h5A; cfg_en = 1'b1;
    step(1);
    cfg_we = 1'b0;
    push(3, 32'h0000005A);
    expect_out(2'd3, 32'h0000005A, 1'b1);
    wait_drain("t4_drain", 40);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t4_dut2_drop_cnt", 32'(drop_cnt2), 32'd1);
    check("t4_dut2_no_fwd", 32'(seen_valid2), 32'd0);

    // 5: backpressure
    grant_log.delete();
    out_ready = 1'b0;
    w_a = mkpar(32'h00ABCD77);
    w_b = mkpar(32'h00001288);
    push(0, w_a);
    push(1, w_b);
    expect_out(2'd0, w_a, 1'b0);
    expect_out(2'd1, w_b, 1'b0);
    wait_valid("t5_valid", 20);
    rd_during = 0;
    changed = 0;
    repeat (10) begin
      @(negedge clk);
      if (rx_rd != 4'b0) rd_during++;
      if (out_word !== w_a || out_ch !== 2'd0 || !out_valid) changed++;
    end
    check("t5_no_rd", 32'(rd_during), 32'd0);
    check("t5_stable", 32'(changed), 32'd0);
    check("t5_ch1_waiting", 32'(rx_empty[1]), 32'd0);
    step(1);
    out_ready = 1'b1;
    wait_drain("t5_drain", 40);
    check("t5_grants", grants_enc(), 32'h01);

    // 6: reset while a word is presented
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_label = 8'h5A; cfg_en = 1'b0;
    step(1);
    cfg_we = 1'b0;
    push(2, mkpar(32'h00000022));
    wait_valid("t6_valid", 20);
    step(1);
    clr = 1'b1;
    #1;
    sb_q.delete();
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_word", out_word, 32'h0);
    check("t6_rst_ch", 32'(out_ch), 32'd0);
    check("t6_rst_perr", 32'(out_parity_err), 32'd0);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    check("t6_rst_rd", 32'(rx_rd), 32'd0);
    step(1);
    clr = 1'b0;
    out_ready = 1'b1;
    grant_log.delete();
    w_q = mkpar(32'h00000099);
    push(1, w_q);
    push(0, 32'h8000005A);
    expect_out(2'd0, 32'h8000005A, 1'b0);
    expect_out(2'd1, w_q, 1'b0);
    wait_drain("t6_drain", 60);
    check("t6_grants", grants_enc(), 32'h01);
    check("t6_drop_cnt", 32'(drop_cnt), 32'd0);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
